mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multi-cycle control unit for the MIPS datapath: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback. It drives the write enables of the datapath's enabled state registers (PC, IR) and the register file, memory and mux select lines. It also consumes a memory-ready handshake so that slow memory inserts wait cycles. It sits between the instruction register (opcode source) and every enabled register and mux in the datapath.

## Interface
- No parameters; all encodings are fixed constants in the package.
- CLK  in  1  system clock, all state changes on rising edge
- RST  in  1  synchronous, active-low reset (sampled on rising CLK)
- Op  in  6  opcode, bits [31:26] of the instruction register; stable from DECODE onward
- Zero  in  1  ALU zero flag, combinational from the current cycle
- mem_ready  in  1  memory completes the current read or write this cycle
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register enable
- RegDst  out  1  write register select: 0 = rt, 1 = rd
- MemtoReg  out  1  writeback data select: 0 = ALUOut, 1 = memory data register
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A register
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
- ALUOp  out  2  00 = add, 01 = subtract, 10 = decode from funct field
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- PCEn  out  1  PC register enable
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode

## Operation
- Supported opcodes:
  - R-type 000000, LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000, J 000010.
  - Any other opcode is illegal.
- Outputs are decoded purely from the state, plus Zero, Op and mem_ready where noted. Any output not listed for a state is 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite = PCEn = mem_ready.
  - Go to DECODE when mem_ready=1; otherwise stay in FETCH.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state by opcode: LW/SW → MEMADR, R-type → EXECUTE, BEQ/BNE → BRANCH, ADDI → ADDIEX, J → JUMP.
  - Illegal opcode → FETCH, with illegal_op=1 for this cycle only.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMRD for LW, MEMWR for SW.
- MEMRD: IorD=1, MemRead=1. Go to MEMWB on mem_ready, else hold.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next is FETCH.
- MEMWR: IorD=1, MemWrite=1, held until mem_ready. Go to FETCH on mem_ready.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next is ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next is FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01.
  - PCEn = Zero for BEQ, ~Zero for BNE.
  - Next is FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next is FETCH.
- JUMP: PCSrc=10, PCEn=1. Next is FETCH.
- Reset:
  - While RST=0, every enable output is forced to 0: IRWrite, PCEn, RegWrite, MemWrite, MemRead, illegal_op. All select outputs are 0.
  - The state becomes FETCH at the first rising CLK edge with RST=0.
  - A reset asserted in the middle of an instruction abandons it. No partial register-file or memory write occurs in the reset cycle.
- The state register must never hold an unused encoding. An unreachable encoding recovers to FETCH on the next edge.

## Timing
- Cycles per instruction with mem_ready held at 1:
  - LW 5, SW 4, R-type 4, ADDI 4, BEQ/BNE 3, J 3.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. Outputs stay constant across wait cycles.
- PCEn and IRWrite rise in the same cycle as mem_ready in FETCH. The PC and IR update on that cycle's closing edge.
- Zero is sampled combinationally in BRANCH. Op is sampled in DECODE, MEMADR and BRANCH.
- No combinational path exists from mem_ready to the state register other than through the next-state logic; PCEn is the only output that depends on Zero.

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum (12 states),
  - the opcode constants,
  - the ALUSrcB, ALUOp and PCSrc encodings.
- The block is a single module with no sub-modules: one state register, a next-state block and an output decoder.
- The PC and IR enabled registers are instantiated in the datapath, not here.

## Test plan
- Reset: RST=0 for 2 cycles with mem_ready=1 → all enables 0. After release, the first cycle is FETCH with MemRead=1, PCEn=1, IRWrite=1.
- LW with Op=100011, mem_ready=1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. RegWrite=1 and MemtoReg=1 only in cycle 5.
- SW with mem_ready low for 3 cycles in MEMWR → MemWrite=1 and IorD=1 for 4 cycles, then FETCH. RegWrite is never asserted.
- Branches:
  - BEQ with Zero=1 → PCEn=1 and PCSrc=01 in cycle 3.
  - BNE with Zero=1 → PCEn=0 in cycle 3.
  - Both return to FETCH.
- J and R-type:
  - J → PCEn=1 and PCSrc=10 in cycle 3.
  - R-type → ALUOp=10 in cycle 3, then RegWrite=1 and RegDst=1 in cycle 4.
- Illegal opcode and mid-instruction reset:
  - Op=111111 → illegal_op pulses for exactly 1 cycle in DECODE, then FETCH.
  - RST=0 during MEMWB → RegWrite=0 in that cycle.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: state enum,
// supported opcodes and the datapath mux select codes.
// Pure declarations; no logic lives here beyond the opcode legality helper.
`timescale 1ns/1ps
package mc_ctrl_pkg;

    // Twelve states fit in 4 bits; the four spare codes are unreachable and
    // the next-state logic steers them back to S_FETCH.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    // Opcodes, instruction bits [31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU B operand select
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // ALU operation
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW)  || (op == OP_SW)  ||
               (op == OP_BEQ)   || (op == OP_BNE) || (op == OP_ADDI) ||
               (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback.
// Latency: outputs are a combinational decode of the current state (plus Op/Zero/mem_ready).
// Backpressure: mem_ready=0 holds FETCH, MEMRD and MEMWR with outputs unchanged.
//
// Ports:
//   CLK, RST        clock and synchronous active-low reset
//   Op, Zero        opcode from IR, ALU zero flag
//   mem_ready       memory completes the current access this cycle
//   IorD..PCEn      datapath enables and mux selects
//   illegal_op      one-cycle pulse in DECODE on an unsupported opcode
`timescale 1ns/1ps
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] Op,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       illegal_op
);

    state_t r_state;
    state_t w_next;

    // State register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. Every branch yields a named state, so the register can
    // only ever load a used encoding; spare codes fall to S_FETCH.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW:    w_next = S_MEMADR;
                    OP_RTYPE:        w_next = S_EXECUTE;
                    OP_BEQ, OP_BNE:  w_next = S_BRANCH;
                    OP_ADDI:         w_next = S_ADDIEX;
                    OP_J:            w_next = S_JUMP;
                    default:         w_next = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   w_next = S_FETCH;
            S_MEMWR:   w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: w_next = S_ALUWB;
            S_ALUWB:   w_next = S_FETCH;
            S_BRANCH:  w_next = S_FETCH;
            S_ADDIEX:  w_next = S_ADDIWB;
            S_ADDIWB:  w_next = S_FETCH;
            S_JUMP:    w_next = S_FETCH;
            default:   w_next = S_FETCH;
        endcase
    end

    // Output decoder. RST gates everything so that a reset landing in a
    // writeback or store state never leaks a partial write.
    always_comb begin
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_B;
        ALUOp      = ALUOP_ADD;
        PCSrc      = PCSRC_ALU;
        PCEn       = 1'b0;
        illegal_op = 1'b0;
        if (RST) begin
            case (r_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    // PC+4 and the new instruction latch on the edge closing
                    // the cycle in which memory delivers.
                    IRWrite = mem_ready;
                    PCEn    = mem_ready;
                end
                S_DECODE: begin
                    // Branch target computed speculatively into ALUOut.
                    ALUSrcB    = SRCB_IMMSH;
                    illegal_op = ~is_legal_op(Op);
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMRD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                S_MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_SUB;
                    PCSrc   = PCSRC_ALUOUT;
                    // Only output that depends on Zero.
                    PCEn    = (Op == OP_BNE) ? ~Zero : Zero;
                end
                S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_ADDIWB: begin
                    RegWrite = 1'b1;
                end
                S_JUMP: begin
                    PCSrc = PCSRC_JUMP;
                    PCEn  = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
`timescale 1ns/1ps
module tb_mc_control_fsm;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [5:0] Op = 6'd0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       PCEn, illegal_op;

    mc_control_fsm dut (
        .CLK(CLK), .RST(RST), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
        .illegal_op(illegal_op)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb, aluop, pcsrc;
        logic       pcen, illegal;
    } ctl_t;

    // Instruction steps (bench's own labels for the cycles of an instruction)
    localparam int P_FETCH = 0, P_DEC = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4,
                   P_MEMWR = 5, P_EXEC = 6, P_ALUWB = 7, P_BRANCH = 8, P_ADDIEX = 9,
                   P_ADDIWB = 10, P_JUMP = 11;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                           BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000,
                           JMP = 6'b000010;

    ctl_t expq[$];
    int   total = 0;
    int   bad   = 0;
    int   k;
    int   rst_step;
    bit   aborted;

    function automatic bit legal(input logic [5:0] op);
        return op == RT || op == LW || op == SW || op == BEQ || op == BNE ||
               op == ADDI || op == JMP;
    endfunction

    // Expected control word for one cycle of an instruction.
    function automatic ctl_t exp_out(input int s, input bit mr, input bit z, input logic [5:0] op);
        ctl_t e;
        e = '0;
        case (s)
            P_FETCH:  begin e.memread = 1; e.alusrcb = 2'b01; e.irwrite = mr; e.pcen = mr; end
            P_DEC:    begin e.alusrcb = 2'b11; e.illegal = !legal(op); end
            P_MEMADR: begin e.alusrca = 1; e.alusrcb = 2'b10; end
            P_MEMRD:  begin e.iord = 1; e.memread = 1; end
            P_MEMWB:  begin e.memtoreg = 1; e.regwrite = 1; end
            P_MEMWR:  begin e.iord = 1; e.memwrite = 1; end
            P_EXEC:   begin e.alusrca = 1; e.aluop = 2'b10; end
            P_ALUWB:  begin e.regdst = 1; e.regwrite = 1; end
            P_BRANCH: begin
                e.alusrca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01;
                e.pcen = (op == BEQ) ? z : !z;
            end
            P_ADDIEX: begin e.alusrca = 1; e.alusrcb = 2'b10; end
            P_ADDIWB: begin e.regwrite = 1; end
            P_JUMP:   begin e.pcsrc = 2'b10; e.pcen = 1; end
            default:  e = '0;
        endcase
        return e;
    endfunction

    // Drive one cycle and queue its expected outputs; a reset injected at
    // cycle rst_step abandons the rest of the instruction.
    task automatic step(input int s, input bit mr, input bit z, input logic [5:0] op);
        ctl_t e;
        if (aborted) return;
        @(posedge CLK);
        #1;
        if (rst_step == k) begin
            RST = 1'b0;
            e = '0;
            aborted = 1'b1;
        end else begin
            RST = 1'b1;
            e = exp_out(s, mr, z, op);
        end
        mem_ready = mr;
        Zero = z;
        Op = op;
        expq.push_back(e);
        k++;
    endtask

    task automatic rst_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            RST = 1'b0;
            mem_ready = 1'b1;
            Zero = 1'($urandom);
            expq.push_back('0);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    task automatic run_instr(input logic [5:0] op, input bit z, input int fw,
                             input int mw, input int rs);
        k = 0;
        rst_step = rs;
        aborted = 1'b0;
        for (int i = 0; i < fw; i++) step(P_FETCH, 1'b0, rb(), 6'($urandom));
        step(P_FETCH, 1'b1, rb(), 6'($urandom));
        step(P_DEC, rb(), rb(), op);
        case (op)
            LW: begin
                step(P_MEMADR, rb(), rb(), op);
                for (int i = 0; i < mw; i++) step(P_MEMRD, 1'b0, rb(), op);
                step(P_MEMRD, 1'b1, rb(), op);
                step(P_MEMWB, rb(), rb(), op);
            end
            SW: begin
                step(P_MEMADR, rb(), rb(), op);
                for (int i = 0; i < mw; i++) step(P_MEMWR, 1'b0, rb(), op);
                step(P_MEMWR, 1'b1, rb(), op);
            end
            RT: begin
                step(P_EXEC, rb(), rb(), op);
                step(P_ALUWB, rb(), rb(), op);
            end
            ADDI: begin
                step(P_ADDIEX, rb(), rb(), op);
                step(P_ADDIWB, rb(), rb(), op);
            end
            BEQ, BNE: step(P_BRANCH, rb(), z, op);
            JMP: step(P_JUMP, rb(), rb(), op);
            default: ;
        endcase
    endtask

    // Monitor: every cycle the DUT presents a control word; compare mid-cycle.
    always @(negedge CLK) begin
        ctl_t act, e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            act = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                   ALUSrcB, ALUOp, PCSrc, PCEn, illegal_op};
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL ctl t=%0t act=%h exp=%h", $time, act, e);
            end
        end
    end

    localparam logic [5:0] OPS [0:7] = '{LW, SW, RT, BEQ, BNE, ADDI, JMP, 6'b111111};

    initial begin
        logic [5:0] op;
        rst_cycles(2);
        // Directed
        run_instr(LW,   1'b0, 0, 0, -1);
        run_instr(SW,   1'b0, 0, 3, -1);
        run_instr(BEQ,  1'b1, 0, 0, -1);
        run_instr(BNE,  1'b1, 0, 0, -1);
        run_instr(BEQ,  1'b0, 1, 0, -1);
        run_instr(BNE,  1'b0, 0, 0, -1);
        run_instr(JMP,  1'b0, 0, 0, -1);
        run_instr(RT,   1'b0, 0, 0, -1);
        run_instr(ADDI, 1'b0, 2, 0, -1);
        run_instr(6'b111111, 1'b0, 0, 0, -1);
        run_instr(LW,   1'b0, 0, 0, 4);   // reset lands on the register writeback cycle
        run_instr(LW,   1'b0, 1, 2, -1);
        run_instr(SW,   1'b0, 0, 1, 3);   // reset during the store
        // Random
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom);
            else op = OPS[$urandom_range(0, 7)];
            run_instr(op, rb(), $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1);
        end
        @(posedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d exp=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
